// File: rtl/cs_addsub_serial_pkg.sv
// ============================================================================
// Module      : cs_addsub_serial_pkg
// Description : Shared constants, state encoding and index sizing for the
//               nibble-serial carry-select adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cs_addsub_serial_pkg;

    localparam int NIBBLE_W      = 4;
    localparam int DEFAULT_WIDTH = 32;
    localparam int IDX_W_DEFAULT = $clog2(DEFAULT_WIDTH / NIBBLE_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice index width; a lone slice still needs a 1-bit counter.
    function automatic int idx_width(input int width);
        int n_slices;
        n_slices = width / NIBBLE_W;
        return (n_slices > 1) ? $clog2(n_slices) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cs_addsub_serial_slice4.sv
// ============================================================================
// Module      : cs_slice4
// Description : Combinational 4-bit carry-select slice; both carry-in sums are
//               formed up front and the carry-in picks one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cs_slice4
    import cs_addsub_serial_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] w_sum_c0;
    logic [NIBBLE_W:0] w_sum_c1;

    assign w_sum_c0 = {1'b0, a} + {1'b0, b};
    assign w_sum_c1 = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, 1'b1};

    assign {cout, s} = cin ? w_sum_c1 : w_sum_c0;

endmodule

`default_nettype wire

// File: rtl/cs_addsub_serial.sv
// ============================================================================
// Module      : cs_addsub_serial
// Description : Nibble-serial WIDTH-bit adder/subtractor reusing one carry-select
//               slice per cycle, with start/ready/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cs_addsub_serial
    import cs_addsub_serial_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] din1_i,
    input  logic [WIDTH-1:0] din2_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    localparam int                c_IDX_W    = idx_width(WIDTH);
    localparam int                c_N_SLICES = WIDTH / NIBBLE_W;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_N_SLICES - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_carry_out;
    logic               r_ovf;
    logic [c_IDX_W-1:0] r_idx;

    logic               w_last;
    logic [NIBBLE_W-1:0] w_slice_s;
    logic               w_slice_cout;

    assign w_last = (r_idx == c_LAST_IDX);

    cs_slice4 u_slice (
        .a    (r_a[{r_idx, 2'b00} +: NIBBLE_W]),
        .b    (r_b[{r_idx, 2'b00} +: NIBBLE_W]),
        .cin  (r_carry),
        .s    (w_slice_s),
        .cout (w_slice_cout)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start_i) w_next_state = RUN;
            RUN:     if (w_last)  w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Subtract is A + ~B + 1: B is inverted at capture and the +1 enters as
    // the initial running carry.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_ovf       <= 1'b0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_a     <= din1_i;
                        r_b     <= sub_i ? ~din2_i : din2_i;
                        r_carry <= sub_i;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                RUN: begin
                    r_sum[{r_idx, 2'b00} +: NIBBLE_W] <= w_slice_s;
                    r_carry <= w_slice_cout;
                    r_idx   <= r_idx + c_IDX_W'(1);
                    if (w_last) begin
                        r_carry_out <= w_slice_cout;
                        r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                       (w_slice_s[NIBBLE_W-1] != r_a[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o = (r_state == IDLE);
    assign done_o  = (r_state == DONE);
    assign sum_o   = r_sum;
    assign carry_o = r_carry_out;
    assign ovf_o   = r_ovf;

endmodule

`default_nettype wire
